// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, branch redirect and decode.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction prefetcher: credit-limited requests into a DEPTH-entry FIFO,
// with branch redirects flushing the queue and dropping responses still in flight.
module instruction_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_unit_if.master ifu_io
);
    localparam int unsigned        PTR_W   = $clog2(DEPTH);
    localparam int unsigned        CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] FULL    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W:0]   credits_d;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic        req_valid;
    logic        inst_valid;
    logic        acc;
    logic        rsp_take;
    logic        q_wr;
    logic        q_rd;
    logic [31:0] redirect_target;
    logic [1:0]  unused_redirect_lsbs;

    assign req_valid       = (state_q == FETCH) && !rst;
    assign inst_valid      = (count_q != '0);
    assign acc             = req_valid && ifu_io.imem_req_ready;
    // With nothing outstanding a response cannot belong to us (e.g. left over from before reset).
    assign rsp_take        = ifu_io.imem_rsp_valid && (outst_q != '0);
    assign q_wr            = rsp_take && !ifu_io.redirect_valid && (discard_q == '0);
    assign q_rd            = inst_valid && ifu_io.inst_ready;
    assign redirect_target = {ifu_io.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ifu_io.redirect_pc[1:0];

    assign ifu_io.imem_req_valid = req_valid;
    assign ifu_io.imem_req_addr  = pc_q;
    assign ifu_io.inst_valid     = inst_valid;
    assign ifu_io.inst_data      = inst_valid ? data_mem[rd_ptr_q] : '0;
    assign ifu_io.inst_pc        = inst_valid ? pc_mem[rd_ptr_q]   : '0;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        discard_d = discard_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        credits_d = '0;
        outst_d   = outst_q + CNT_W'(acc) - CNT_W'(rsp_take);

        if (ifu_io.redirect_valid) begin
            // Everything still in flight after this edge was fetched down the old path.
            pc_d      = redirect_target;
            rsp_pc_d  = redirect_target;
            discard_d = outst_d;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            state_d   = (outst_d != '0) ? DISCARD : FETCH;
        end else begin
            if (acc) begin
                pc_d = pc_q + 32'd4;
            end
            if (q_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (q_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(q_wr) - CNT_W'(q_rd);
            if (rsp_take && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            credits_d = {1'b0, count_d} + {1'b0, outst_d};
            if (state_q == DISCARD) begin
                state_d = (discard_d == '0) ? FETCH : DISCARD;
            end else begin
                state_d = (credits_d >= {1'b0, DEPTH_C}) ? FULL : FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Queue storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (q_wr) begin
            data_mem[wr_ptr_q] <= ifu_io.imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end
endmodule
